uart_kernel_sysid_checker: RTL and testbench

//  Avalon-MM master that reads the system-ID slave (word 0 = ID, word 1 = build timestamp) and compares

---
 rtl/uart_kernel_sysid_checker.sv | 159 +++++++++++++++
 tb/tb_uart_kernel_sysid_checker.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_kernel_sysid_checker.sv
// Avalon-MM master that reads the sysid slave (ID, timestamp) and compares both words.
// Ports: clock/reset/start in; avm_* bus; busy, done, pass, err_code, id_value, ts_value out.
module uart_kernel_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1599482139,
  parameter int          CHECK_TS       = 1,
  parameter int          AUTO_START     = 1,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          TO_W           = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  err_code,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    CHECK = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t            r_state;
  logic              r_auto;
  logic [TO_W-1:0]   r_cnt;
  logic              r_addr;
  logic              r_read;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [1:0]        r_err;
  logic [31:0]       r_id;
  logic [31:0]       r_ts;

  logic              w_to_hit;

  // Last stall cycle allowed before the read is abandoned.
  assign w_to_hit = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

  // Verdict is computed on the transfer that ends the last read so that
  // pass/err_code are already valid in the cycle done is high.
  function automatic logic [1:0] f_err(input logic [31:0] id,
                                       input logic [31:0] ts);
    if (id != EXPECTED_ID)
      return 2'd1;
    if ((CHECK_TS != 0) && (ts != EXPECTED_TS))
      return 2'd2;
    return 2'd0;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_auto  <= (AUTO_START != 0);
      r_cnt   <= '0;
      r_addr  <= 1'b0;
      r_read  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= 2'd0;
      r_id    <= '0;
      r_ts    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start || r_auto) begin
            r_auto  <= 1'b0;
            r_state <= RD_ID;
            r_addr  <= 1'b0;
            r_read  <= 1'b1;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_pass  <= 1'b0;
            r_err   <= 2'd0;
            r_id    <= '0;
            r_ts    <= '0;
          end
        end
        RD_ID: begin
          if (!avm_waitrequest) begin
            r_id  <= avm_readdata;
            r_cnt <= '0;
            if (CHECK_TS != 0) begin
              r_state <= RD_TS;
              r_addr  <= 1'b1;
            end else begin
              r_state <= CHECK;
              r_read  <= 1'b0;
              r_done  <= 1'b1;
              r_err   <= f_err(avm_readdata, 32'd0);
              r_pass  <= (f_err(avm_readdata, 32'd0) == 2'd0);
            end
          end else if (w_to_hit) begin
            r_state <= CHECK;
            r_read  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 2'd3;
            r_pass  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RD_TS: begin
          if (!avm_waitrequest) begin
            r_ts    <= avm_readdata;
            r_state <= CHECK;
            r_read  <= 1'b0;
            r_addr  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= f_err(r_id, avm_readdata);
            r_pass  <= (f_err(r_id, avm_readdata) == 2'd0);
          end else if (w_to_hit) begin
            r_state <= CHECK;
            r_read  <= 1'b0;
            r_addr  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 2'd3;
            r_pass  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        CHECK: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_read  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign avm_address = r_addr;
  assign avm_read    = r_read;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign err_code    = r_err;
  assign id_value    = r_id;
  assign ts_value    = r_ts;

endmodule

// File: tb/tb_uart_kernel_sysid_checker.sv
// Bench for uart_kernel_sysid_checker: model sysid slave, scoreboard on done.
// Ports: none.
module tb_uart_kernel_sysid_checker;

  localparam logic [31:0] TS = 32'd1599482139;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  err_code;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  logic [31:0] word0 = 32'd0;
  logic [31:0] word1 = TS;
  int          stall0 = 0;
  logic        stuck = 1'b0;
  int          scnt = 0;

  uart_kernel_sysid_checker dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_code        (err_code),
    .id_value        (id_value),
    .ts_value        (ts_value)
  );

  always #5 clock = ~clock;

  assign avm_readdata    = avm_address ? word1 : word0;
  assign avm_waitrequest = stuck |
    (avm_read & ~avm_address & (scnt < stall0));

  always @(posedge clock)
    scnt <= (avm_read && avm_waitrequest) ? scnt + 1 : 0;

  typedef struct {
    logic        p;
    logic [1:0]  e;
    logic [31:0] id;
    logic [31:0] ts;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ndone  = 0;
  int   npush  = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_run(input logic p, input logic [1:0] e,
                            input logic [31:0] id,
                            input logic [31:0] ts);
    exp_t x;
    x.p  = p;
    x.e  = e;
    x.id = id;
    x.ts = ts;
    q.push_back(x);
    npush++;
  endtask

  exp_t m;
  always @(negedge clock) begin
    if (done === 1'b1) begin
      ndone++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_done: got done=1, expected no done");
      end else begin
        m = q.pop_front();
        check("sb_pass", {31'd0, pass}, {31'd0, m.p});
        check("sb_err", {30'd0, err_code}, {30'd0, m.e});
        check("sb_id", id_value, m.id);
        check("sb_ts", ts_value, m.ts);
      end
    end
  end

  task automatic step();
    @(negedge clock);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int first, input int budget,
                           output int n);
    n = first;
    while (done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done, expected done by %0d", budget);
    end
  endtask

  initial begin
    int n;
    int rd;

    // Reset state
    repeat (3) step();
    check("rst_ctl",
          {26'd0, avm_read, avm_address, busy, done, pass, err_code},
          32'd0);
    check("rst_id", id_value, 32'd0);
    check("rst_ts", ts_value, 32'd0);

    // 1: auto start, zero wait
    expect_run(1'b1, 2'd0, 32'd0, TS);
    reset = 1'b0;
    step();
    check("t1_c1", {29'd0, avm_read, avm_address, busy}, 32'b101);
    step();
    check("t1_c2", {30'd0, avm_read, avm_address}, 32'b11);
    step();
    check("t1_done", {30'd0, done, avm_read}, 32'b10);
    step();
    step();
    check("t1_idle", {30'd0, busy, done}, 32'd0);

    // 2: timestamp mismatch
    word1 = 32'h1234_5678;
    expect_run(1'b0, 2'd2, 32'd0, 32'h1234_5678);
    pulse_start();
    wait_done(1, 10, n);
    check("t2_lat", n, 3);
    word1 = TS;
    step();

    // ID mismatch has priority over TS
    word0 = 32'hDEAD_BEEF;
    word1 = 32'h1;
    expect_run(1'b0, 2'd1, 32'hDEAD_BEEF, 32'h1);
    pulse_start();
    wait_done(1, 10, n);
    check("tid_lat", n, 3);
    word0 = 32'd0;
    word1 = TS;
    step();

    // 3: three stall cycles on addr 0
    stall0 = 3;
    expect_run(1'b1, 2'd0, 32'd0, TS);
    pulse_start();
    for (int i = 1; i <= 4; i++) begin
      check("t3_hold", {30'd0, avm_read, avm_address}, 32'b10);
      step();
    end
    check("t3_ts", {30'd0, avm_read, avm_address}, 32'b11);
    wait_done(5, 20, n);
    check("t3_lat", n, 6);
    stall0 = 0;
    step();

    // 4: waitrequest stuck high -> timeout
    stuck = 1'b1;
    expect_run(1'b0, 2'd3, 32'd0, 32'd0);
    pulse_start();
    rd = 0;
    n = 1;
    while (done !== 1'b1 && n < 400) begin
      if (avm_read === 1'b1)
        rd++;
      step();
      n++;
    end
    check("t4_stalls", rd, 255);
    check("t4_lat", n, 256);
    check("t4_rd", {31'd0, avm_read}, 32'd0);
    stuck = 1'b0;
    step();

    // 5: reset in RD_TS, then auto relaunch
    pulse_start();
    step();
    check("t5_rdts", {30'd0, avm_read, avm_address}, 32'b11);
    reset = 1'b1;
    step();
    check("t5_clr",
          {26'd0, avm_read, avm_address, busy, done, pass, err_code},
          32'd0);
    check("t5_id", id_value, 32'd0);
    step();
    expect_run(1'b1, 2'd0, 32'd0, TS);
    reset = 1'b0;
    step();
    wait_done(1, 10, n);
    check("t5_lat", n, 3);
    step();

    // 6: start during busy ignored, pass cleared during run
    expect_run(1'b1, 2'd0, 32'd0, TS);
    pulse_start();
    check("t6_pass_clr", {31'd0, pass}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(2, 10, n);
    check("t6_lat", n, 3);
    repeat (6) step();
    check("t6_idle", {31'd0, busy}, 32'd0);
    check("t6_hold", {29'd0, pass, err_code}, 32'b100);

    repeat (2) step();
    check("sb_left", q.size(), 0);
    check("sb_count", ndone, npush);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
